// File: rtl/registro_etapa_pkg.sv
// rtl/registro_etapa_pkg.sv - shared constants for the registro_etapa_vec pipeline stage
//
// Holds the occupancy state encoding, the default payload widths and the bit
// offsets of the fields in the 16-bit control bundle (MSB first: sel_op,
// sel_int, sel_vec[1:0], opcode[3:0], sel_pcmem, sum_mem, sel_mem, sel_data,
// mem_wr, sel_wb, reg_wrv, reg_wrs).
package registro_etapa_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int DEF_NLANES = 4;
    localparam int DEF_LANE_W = 8;
    localparam int DEF_SCA_W  = 8;
    localparam int DEF_DEST_W = 3;
    localparam int DEF_CTRL_W = 16;

    localparam int DEF_PAYLOAD_W = 3 * DEF_NLANES * DEF_LANE_W + 3 * DEF_SCA_W
                                 + DEF_DEST_W + DEF_CTRL_W;

    localparam int CTRL_SEL_OP    = 15;
    localparam int CTRL_SEL_INT   = 14;
    localparam int CTRL_SEL_VEC   = 12;
    localparam int CTRL_OPCODE    = 8;
    localparam int CTRL_SEL_PCMEM = 7;
    localparam int CTRL_SUM_MEM   = 6;
    localparam int CTRL_SEL_MEM   = 5;
    localparam int CTRL_SEL_DATA  = 4;
    localparam int CTRL_MEM_WR    = 3;
    localparam int CTRL_SEL_WB    = 2;
    localparam int CTRL_REG_WRV   = 1;
    localparam int CTRL_REG_WRS   = 0;

endpackage

// File: rtl/registro_etapa_slot.sv
// rtl/registro_etapa_slot.sv - load-enabled payload register for one stage slot
//
// Ports: clk, rst (sync, active-high, clears to zero), load (capture d),
// d / q (flattened payload of width W).
module registro_etapa_slot
    import registro_etapa_pkg::*;
#(
    parameter int W = DEF_PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/registro_etapa_vec.sv
// rtl/registro_etapa_vec.sv - parametrised vector pipeline-stage register with valid/ready
//
// Ports: clk, rst (sync, active-high), flush (drop held and incoming entries);
// upstream in_valid/in_ready with in_vec1, in_vec2, in_vfs, in_sca, in_imm,
// in_shift, in_dest, in_ctrl; downstream out_valid/out_ready with the matching
// out_* payload. out_ctrl reads zero whenever out_valid is low.
// Build option REGISTRO_ETAPA_SKID_EN adds a second (skid) slot so that
// in_ready comes straight from a register; without it a single slot is used
// and in_ready is combinational from out_ready.
module registro_etapa_vec
    import registro_etapa_pkg::*;
#(
    parameter int NLANES = DEF_NLANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int SCA_W  = DEF_SCA_W,
    parameter int DEST_W = DEF_DEST_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NLANES*LANE_W-1:0] in_vec1,
    input  logic [NLANES*LANE_W-1:0] in_vec2,
    input  logic [NLANES*LANE_W-1:0] in_vfs,
    input  logic [SCA_W-1:0]         in_sca,
    input  logic [SCA_W-1:0]         in_imm,
    input  logic [SCA_W-1:0]         in_shift,
    input  logic [DEST_W-1:0]        in_dest,
    input  logic [CTRL_W-1:0]        in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NLANES*LANE_W-1:0] out_vec1,
    output logic [NLANES*LANE_W-1:0] out_vec2,
    output logic [NLANES*LANE_W-1:0] out_vfs,
    output logic [SCA_W-1:0]         out_sca,
    output logic [SCA_W-1:0]         out_imm,
    output logic [SCA_W-1:0]         out_shift,
    output logic [DEST_W-1:0]        out_dest,
    output logic [CTRL_W-1:0]        out_ctrl
);

    localparam int VEC_W = NLANES * LANE_W;
    localparam int PAY_W = 3 * VEC_W + 3 * SCA_W + DEST_W + CTRL_W;

    logic [PAY_W-1:0]  in_payload;
    logic [PAY_W-1:0]  main_d;
    logic [PAY_W-1:0]  main_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              main_load;
    logic              accept;
    logic              drain;

    assign in_payload = {in_vec1, in_vec2, in_vfs, in_sca, in_imm, in_shift, in_dest, in_ctrl};
    assign {out_vec1, out_vec2, out_vfs, out_sca, out_imm, out_shift, out_dest, main_ctrl} = main_q;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Bubbles must never carry a live write enable downstream.
    assign out_ctrl  = out_valid ? main_ctrl : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    registro_etapa_slot #(.W(PAY_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

`ifdef REGISTRO_ETAPA_SKID_EN
    logic [PAY_W-1:0] skid_q;
    logic             skid_load;
    logic             in_ready_q;

    // Main slot always holds the oldest entry; skid only ever fills behind it.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_payload;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end else if (accept) begin
                        main_load = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        state_d   = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    registro_etapa_slot #(.W(PAY_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_payload),
        .q    (skid_q)
    );

    // Registered from next state so in_ready never combinationally sees out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid || out_ready;
    assign main_d   = in_payload;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
    end
`endif

endmodule

// File: doc/registro_etapa_vec.md
# registro_etapa_vec

Parametrised pipeline-stage register for the vector processor; the next-generation replacement for the fixed-width ID/EXE register, reusable at the ID/EXE, EXE/MEM and MEM/WB boundaries. Carries NLANES vector lanes, one scalar, one immediate, one destination address and a packed control bundle between stages, with a valid/ready handshake, stall back-pressure, a synchronous flush (bubble insertion) and an optional 2-entry skid buffer. All state updates on the rising edge only; there is no negedge output phase.

## Interface
Parameters:
- NLANES, 4: vector lanes per operand.
- LANE_W, 8: bits per lane.
- SCA_W, 8: scalar and immediate width.
- DEST_W, 3: destination register address width.
- CTRL_W, 16: packed control bundle width (EXE, MEM, WB fields).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous and active-high.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_vec1, in_vec2, in_vfs  in  NLANES*LANE_W  vector operands, lane 0 in LSBs.
- in_sca, in_imm, in_shift  in  SCA_W  scalar, immediate, shift amount.
- in_dest  in  DEST_W  destination address.
- in_ctrl  in  CTRL_W  control bundle.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_vec1, out_vec2, out_vfs, out_sca, out_imm, out_shift, out_dest, out_ctrl  out  same widths as inputs  registered entry.

## Operation
- Transfer in: in_valid && in_ready at posedge. Transfer out: out_valid && out_ready at posedge.
- States: EMPTY (no entry), ONE (main slot holds entry), TWO (main and skid slots full; skid build only).
- EMPTY: accept -> ONE.
- ONE: accept without drain -> TWO; accept with drain -> ONE (new entry into main); drain without accept -> EMPTY; neither -> ONE, outputs held.
- TWO: drain -> ONE, skid moves to main; no accept possible (in_ready=0).
- in_ready = (state != TWO), registered from next-state.
- out_ctrl forced to all-zero whenever out_valid=0, so no write enable (mem_wr, reg_wrv, reg_wrs) fires on a bubble. Data outputs hold last value when invalid.
- flush: next state EMPTY, out_valid=0, out_ctrl=0; an input offered in the same cycle is discarded even if in_valid=1. A same-cycle downstream transfer still counts as completed at the receiver.
- Priority: rst > flush > normal transfer.
- Reset: out_valid=0, in_ready=1, all data and control outputs 0, state EMPTY. Reset mid-transfer discards both slots.

## Timing
- Latency 1 cycle: entry accepted at edge N is on outputs, out_valid=1, after edge N.
- Throughput 1 entry/cycle while out_ready=1.
- in_ready depends only on registered state: no in_ready <- out_ready combinational path (skid build).
- Stall: out_ready low for k cycles with continuous input -> at most 2 entries absorbed, then in_ready=0 until first drain; entry order preserved.

## Configuration
- REGISTRO_ETAPA_SKID_EN defined: skid slot and TWO state present, behaviour as above.
- Not defined: single slot only; in_ready = !out_valid || out_ready (combinational from out_ready); no state TWO; latency and flush/reset behaviour unchanged.

## Structure
- Package registro_etapa_pkg: state encoding (EMPTY, ONE, TWO), default widths, control bundle field offsets (sel_op, sel_int, sel_vec[1:0], opcode[3:0], sel_pcmem, sum_mem, sel_mem, sel_data, mem_wr, sel_wb, reg_wrv, reg_wrs = 16 bits).
- One sub-module, registro_etapa_slot: load-enabled payload register, instantiated for main and (when enabled) skid slot.

## Test plan
- Reset: rst=1 two cycles -> out_valid=0, in_ready=1, out_ctrl=0, out_vec1=0.
- Streaming: 8 entries in_vec1=0x01020304+i, out_ready=1 -> each appears 1 cycle after acceptance, in order, out_valid continuous.
- Stall (skid): out_ready=0 for 4 cycles while in_valid=1 -> exactly 2 accepted, in_ready=0 from 3rd cycle; on release, both emerge in order, none lost or duplicated.
- Flush: in state TWO assert flush with in_valid=1, in_ctrl=0xFFFF -> next cycle out_valid=0, out_ctrl=0x0000, flushed entries never appear.
- Bubble gating: in_ctrl with mem_wr=1 accepted then drained, in_valid=0 after -> out_ctrl=0 while out_valid=0.
- Macro off: out_ready toggles every cycle -> in_ready tracks !out_valid||out_ready same cycle; no entry loss.
